// File: rtl/telemetry_uart_tx_if.sv
// Snapshot handshake between the flight controller (master) and the
// telemetry transmitter (slave): one valid/ready pair plus four 16-bit words.
interface telemetry_uart_tx_if;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] word0;
    logic [15:0] word1;
    logic [15:0] word2;
    logic [15:0] word3;

    modport master (
        output frame_valid, word0, word1, word2, word3,
        input  frame_ready
    );

    modport slave (
        input  frame_valid, word0, word1, word2, word3,
        output frame_ready
    );
endinterface

// File: rtl/telemetry_uart_tx.sv
// Framed 8N1 telemetry transmitter: header, sequence number, four big-endian
// words and an additive checksum, sent back-to-back as one 11-byte frame.
module telemetry_uart_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    telemetry_uart_tx_if.slave  bus,
    output logic                TxD,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          seq
);
    localparam int unsigned BAUD_DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state_r;
    logic [BW-1:0]  baud_cnt_r;
    logic [2:0]     bit_cnt_r;
    logic [3:0]     byte_idx_r;
    logic           stop_cnt_r;
    logic [6:0]     shift_r;
    logic           ready_r;
    logic [7:0]     seq_cap_r;
    logic [15:0]    w0_r;
    logic [15:0]    w1_r;
    logic [15:0]    w2_r;
    logic [15:0]    w3_r;
    logic [7:0]     cur_byte_s;
    logic [7:0]     checksum_s;
    logic           baud_end_s;

    function automatic logic [7:0] frame_checksum(
        input logic [7:0]  s,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] c,
        input logic [15:0] d
    );
        return s + a[15:8] + a[7:0] + b[15:8] + b[7:0]
                 + c[15:8] + c[7:0] + d[15:8] + d[7:0];
    endfunction

    assign checksum_s      = frame_checksum(seq_cap_r, w0_r, w1_r, w2_r, w3_r);
    assign baud_end_s      = (baud_cnt_r == BAUD_LAST);
    assign bus.frame_ready = ready_r;

    // Select the byte currently being serialised from the captured snapshot.
    always_comb begin
        cur_byte_s = HEADER;
        case (byte_idx_r)
            4'd0:    cur_byte_s = HEADER;
            4'd1:    cur_byte_s = seq_cap_r;
            4'd2:    cur_byte_s = w0_r[15:8];
            4'd3:    cur_byte_s = w0_r[7:0];
            4'd4:    cur_byte_s = w1_r[15:8];
            4'd5:    cur_byte_s = w1_r[7:0];
            4'd6:    cur_byte_s = w2_r[15:8];
            4'd7:    cur_byte_s = w2_r[7:0];
            4'd8:    cur_byte_s = w3_r[15:8];
            4'd9:    cur_byte_s = w3_r[7:0];
            4'd10:   cur_byte_s = checksum_s;
            default: cur_byte_s = 8'hFF;
        endcase
    end

    // Frame FSM with registered line and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= 4'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= 7'd0;
            ready_r    <= 1'b1;
            seq_cap_r  <= 8'd0;
            w0_r       <= 16'd0;
            w1_r       <= 16'd0;
            w2_r       <= 16'd0;
            w3_r       <= 16'd0;
            TxD        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            seq        <= 8'd0;
        end else begin
            case (state_r)
                // DONE also accepts, which gives a single idle-high cycle between frames.
                IDLE, DONE: begin
                    frame_done <= 1'b0;
                    TxD        <= 1'b1;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= 3'd0;
                    byte_idx_r <= 4'd0;
                    stop_cnt_r <= 1'b0;
                    if (bus.frame_valid) begin
                        seq_cap_r <= seq;
                        w0_r      <= bus.word0;
                        w1_r      <= bus.word1;
                        w2_r      <= bus.word2;
                        w3_r      <= bus.word3;
                        ready_r   <= 1'b0;
                        busy      <= 1'b1;
                        TxD       <= 1'b0;
                        state_r   <= START;
                    end else begin
                        ready_r <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= 3'd0;
                        TxD        <= cur_byte_s[0];
                        shift_r    <= cur_byte_s[7:1];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == 3'd7) begin
                            TxD        <= 1'b1;
                            stop_cnt_r <= 1'b0;
                            state_r    <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            TxD       <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[6:1]};
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (stop_cnt_r == STOP_LAST) begin
                            stop_cnt_r <= 1'b0;
                            if (byte_idx_r == 4'd10) begin
                                byte_idx_r <= 4'd0;
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                ready_r    <= 1'b1;
                                seq        <= seq + 8'd1;
                                state_r    <= DONE;
                            end else begin
                                byte_idx_r <= byte_idx_r + 4'd1;
                                TxD        <= 1'b0;
                                state_r    <= START;
                            end
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    TxD        <= 1'b1;
                    busy       <= 1'b0;
                    ready_r    <= 1'b1;
                    frame_done <= 1'b0;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= 3'd0;
                    byte_idx_r <= 4'd0;
                    stop_cnt_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
